uart_tx_module: RTL and testbench
=================================

# uart_tx_module

Buffered UART transmitter and the send-side counterpart of the UART receive path. It accepts up to N bytes per cycle into an internal FIFO, built on the shared `multi_push_multi_pop_fifo`. It serializes them one at a time on `tx` as 8N1 frames (start bit, 8 data bits LSB first, stop bit) at `boadrate`. It sits between the DSP result path and the board TX pin.

## Interface
- `clk_mhz`, default 50: clock frequency in MHz.
- `boadrate`, default 9600: line rate in bit/s. Bit period `scale = clk_mhz*1000*1000/boadrate` cycles, integer-truncated; default 5208.
- `DEPTH`, default 4: FIFO depth in bytes.
- `N`, default 4: maximum bytes pushed per cycle.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  [N-1:0][7:0]  push bytes; `data[0]` is the oldest and is sent first.
- `push`  in  $clog2(N+1)  number of bytes offered this cycle, 0..N.
- `can_push`  out  $clog2(N+1)  free FIFO slots, saturated at N.
- `tx`  out  1  serial line, registered, idles high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Push side:
  - If `push > can_push` in a cycle, the whole request is dropped and nothing is written. Partial pushes never happen.
  - Otherwise bytes `data[0..push-1]` are written in index order.
  - A push is accepted in the same cycle as an internal pop; `can_push` reflects occupancy before that edge.
- The FIFO reset is driven by `~rst`. The FIFO pops at most 1 byte per cycle.
- Serializer FSM:
  - **IDLE**: `tx=1`. If the FIFO holds ≥1 byte, pop 1, load the shift register, go to START.
  - **START**: `tx=0` for `scale` cycles, then go to DATA with bit index 0.
  - **DATA**: `tx=shift[0]` for `scale` cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - **STOP**: `tx=1` for `scale` cycles. On the last STOP cycle: if the FIFO is non-empty, pop and go directly to START (gapless); else go to IDLE.
- The bit counter is `$clog2(scale)+1` bits wide. It reloads to `scale-1` on every state or bit change and decrements to 0. A bit ends when the counter reaches 0.
- `tx` is driven from a flop and never glitches. Its value is a function of the registered state and shift register only.
- `busy` = (state != IDLE) | FIFO non-empty.

## Timing
- Reset values: `tx=1`, `busy=0`, `can_push=min(N,DEPTH)`, FSM in IDLE, FIFO empty, counters cleared.
- Reset applies mid-frame: on the edge where `rst=1`, `tx` returns to 1, the current frame is aborted, and buffered bytes are discarded.
- Latency: for a push sampled at edge k into an idle block, the byte is visible in the FIFO after k. The pop occurs at edge k+1, and `tx=0` from edge k+2.
- Frame length is exactly `10*scale` cycles. Consecutive buffered bytes start exactly `10*scale` cycles apart with no idle gap.
- `can_push`:
  - After a push edge, it decreases by `push`.
  - After a pop edge, it increases by 1.
  - Both happen in the same cycle when both occur.
- Full FIFO: `can_push=0`, and any nonzero `push` is ignored. Occupancy wraps correctly across the FIFO end with no reordering.

## Test plan
All scenarios use `clk_mhz=1`, `boadrate=100000` (scale=10), `N=4`, `DEPTH=4`.
- Reset: hold `rst` 3 cycles → `tx=1`, `busy=0`, `can_push=4`. No `tx` transitions for 200 cycles afterwards.
- Single byte 0xA5, `push=1` at edge k:
  - `tx=0` during cycles k+2..k+11, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop bit `1`.
  - `busy` falls at k+102.
- Multi-push 0x01,0x02,0x03 in one cycle (`push=3`):
  - Three frames sent in order 01,02,03, start bits 100 cycles apart.
  - `can_push` goes 4→1, then 2 after the first pop.
- Overflow:
  - `push=4` fills the FIFO; while frame 1 is active, `push=2` with `can_push=1` → request dropped.
  - Exactly the 4 original bytes are transmitted.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0xFF with 2 bytes queued → `tx=1` next edge, `busy=0`, `can_push=4`, no further frames.
- Back-to-back wrap: push 1 byte every 60 cycles for 12 bytes (0x00..0x0B):
  - All 12 appear in order.
  - No frame gap when the FIFO is non-empty.
  - A checker receiver at the same rate decodes them error-free.

Source files
------------

// File: rtl/uart_tx_module.sv
// Buffered 8N1 UART transmitter: multi-byte push FIFO feeding a one-byte-at-a-time
// serializer with a registered, glitch-free tx line.

module multi_push_multi_pop_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int NPUSH = 4,
    parameter int NPOP  = 1
)(
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NPUSH-1:0][W-1:0]             push_data,
    input  logic [$clog2(NPUSH+1)-1:0]          push,
    output logic [$clog2(NPUSH+1)-1:0]          can_push,
    input  logic [$clog2(NPOP+1)-1:0]           pop,
    output logic [NPOP-1:0][W-1:0]              pop_data,
    output logic [$clog2(NPOP+1)-1:0]           can_pop
);
    localparam int PW = $clog2(NPUSH+1);
    localparam int QW = $clog2(NPOP+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]              mem [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             cnt;
    logic [PW-1:0]             n_push;
    logic [QW-1:0]             n_pop;
    logic [NPUSH-1:0]          we;
    logic [NPUSH-1:0][AW-1:0]  widx;
    int                        free_i, used_i;

    // Oversized requests are dropped whole rather than partially written.
    always_comb begin
        free_i   = DEPTH - int'(cnt);
        used_i   = int'(cnt);
        can_push = PW'((free_i > NPUSH) ? NPUSH : free_i);
        can_pop  = QW'((used_i > NPOP) ? NPOP : used_i);
        n_push   = (push <= can_push) ? push : '0;
        n_pop    = (pop <= can_pop) ? pop : '0;
    end

    for (genvar i = 0; i < NPUSH; i++) begin : g_lane
        assign we[i]   = (i < int'(n_push));
        assign widx[i] = AW'((int'(wr_ptr) + i) % DEPTH);
    end

    for (genvar j = 0; j < NPOP; j++) begin : g_rd
        assign pop_data[j] = mem[AW'((int'(rd_ptr) + j) % DEPTH)];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= AW'((int'(wr_ptr) + int'(n_push)) % DEPTH);
            rd_ptr <= AW'((int'(rd_ptr) + int'(n_pop)) % DEPTH);
            cnt    <= CW'(int'(cnt) + int'(n_push) - int'(n_pop));
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NPUSH; i++)
                if (we[i]) mem[widx[i]] <= push_data[i];
        end
    end
endmodule

module uart_tx_module #(
    parameter int clk_mhz  = 50,
    parameter int boadrate = 9600,
    parameter int DEPTH    = 4,
    parameter int N        = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0][7:0]        data,
    input  logic [$clog2(N+1)-1:0]   push,
    output logic [$clog2(N+1)-1:0]   can_push,
    output logic                     tx,
    output logic                     busy
);
    localparam int SCALE = clk_mhz * 1000 * 1000 / boadrate;
    localparam int CNTW  = $clog2(SCALE) + 1;
    localparam logic [CNTW-1:0] RELOAD = CNTW'(SCALE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      shift;
    logic [2:0]      bit_idx;
    logic [CNTW-1:0] cnt;
    logic            tick;
    logic            pop;
    logic            can_pop;
    logic [0:0][7:0] pop_data;

    multi_push_multi_pop_fifo #(
        .W(8), .DEPTH(DEPTH), .NPUSH(N), .NPOP(1)
    ) u_fifo (
        .clk       (clk),
        .rstn      (~rst),
        .push_data (data),
        .push      (push),
        .can_push  (can_push),
        .pop       (pop),
        .pop_data  (pop_data),
        .can_pop   (can_pop)
    );

    assign tick = (cnt == '0);
    // Pop from idle, or on the last stop cycle so back-to-back frames have no gap.
    assign pop  = ((state == IDLE) || (state == STOP && tick)) && can_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            // Line and busy are registered copies of the current state, one cycle behind.
            tx   <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
            busy <= (state != IDLE) || can_pop;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= pop_data[0];
                        cnt   <= RELOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        cnt     <= RELOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= {1'b0, shift[7:1]};
                        cnt     <= RELOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (pop) begin
                            shift <= pop_data[0];
                            cnt   <= RELOAD;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_module.sv
// Randomized + directed bench for uart_tx_module against a queue/timeline model
// of the line, plus an independent serial receiver on tx.

module tb_uart_tx_module;
    localparam int S = 10;
    localparam int N = 4;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0][7:0] data = '0;
    logic [2:0]      push = '0;
    logic [2:0]      can_push;
    logic            tx, busy;

    uart_tx_module #(.clk_mhz(1), .boadrate(100000), .DEPTH(D), .N(N)) dut (
        .clk(clk), .rst(rst), .data(data), .push(push),
        .can_push(can_push), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0, rst_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: queue of buffered bytes plus the frame on the line, tracked by its age
    // in cycles since the pop; each frame spans 10*S cycles.
    logic [7:0] m_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] m_cur;
    bit         m_act = 0;
    int         m_age = 0;
    logic       e_tx, e_busy;
    int         e_cp;

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        int idx, cp;
        if (rst) begin
            if (m_act) void'(sent_q.pop_back());
            m_q.delete();
            m_act = 0;
            m_age = 0;
            e_tx = 1'b1;
            e_busy = 1'b0;
            rst_cnt++;
        end else begin
            e_tx = 1'b1;
            if (m_act) begin
                idx = (m_age - 1) / S;
                if (idx == 0) e_tx = 1'b0;
                else if (idx <= 8) e_tx = m_cur[idx-1];
            end
            e_busy = m_act || (m_q.size() > 0);
            cp = min2(N, D - m_q.size());
            if (m_act && m_age == 10 * S) m_act = 0;
            else if (m_act) m_age++;
            if (!m_act && m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_act = 1;
                m_age = 1;
                sent_q.push_back(m_cur);
            end
            if (int'(push) <= cp)
                for (int i = 0; i < int'(push); i++) m_q.push_back(data[i]);
        end
        e_cp = min2(N, D - m_q.size());
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("can_push", can_push, e_cp);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic put(input int n, input logic [31:0] bytes);
        data = bytes;
        push = n[2:0];
        cycle();
        push = '0;
    endtask

    // Independent receiver: samples mid-bit, aborts on any reset.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_on = 0;
    int         rx_cnt = 0, rx_rst = 0;
    logic [7:0] rx_sh;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_cnt != rx_rst) begin
                rx_rst = rst_cnt;
                rx_on = 0;
            end else if (!rx_on) begin
                if (tx === 1'b0) begin
                    rx_on = 1;
                    rx_cnt = 0;
                    rx_t.push_back(cyc);
                end
            end else begin
                rx_cnt++;
            end
            if (rx_on && (rx_cnt % S) == S / 2) begin
                int j;
                j = rx_cnt / S;
                if (j == 0) chk("rx_start", tx, 0);
                else if (j <= 8) rx_sh[j-1] = tx;
                else begin
                    chk("rx_stop", tx, 1);
                    rx_q.push_back(rx_sh);
                    rx_on = 0;
                end
            end
        end
    end

    initial begin
        int k, first_low, fall, b, w;
        bit seen_busy;

        // Reset held 3 cycles, then a quiet line.
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(200);
        chk("rx_quiet", rx_t.size(), 0);

        // Single byte latency and busy fall.
        put(1, 32'hA5);
        k = cyc;
        first_low = -1;
        fall = -1;
        seen_busy = 0;
        repeat (150) begin
            cycle();
            if (first_low < 0 && tx === 1'b0) first_low = cyc;
            if (busy === 1'b1) seen_busy = 1;
            if (seen_busy && fall < 0 && busy === 1'b0) fall = cyc;
        end
        chk("start_lat", first_low - k, 2);
        chk("busy_fall", fall - k, 102);

        // Three bytes in one push.
        b = rx_t.size();
        put(3, 32'h00030201);
        chk("cp_push3", can_push, 1);
        cycle();
        chk("cp_pop1", can_push, 2);
        run(320);
        chk("mp_frames", rx_t.size() - b, 3);
        if (rx_t.size() - b >= 3) begin
            chk("mp_gap1", rx_t[b+1] - rx_t[b], 100);
            chk("mp_gap2", rx_t[b+2] - rx_t[b+1], 100);
        end

        // Overflowing request while full-but-one is dropped.
        b = rx_q.size();
        put(4, 32'h13121110);
        run(5);
        chk("ovf_cp", can_push, 1);
        put(2, 32'h0000EFEE);
        run(450);
        chk("ovf_frames", rx_q.size() - b, 4);

        // Reset in data bit 3 of 0xFF with two bytes queued.
        put(1, 32'hFF);
        put(2, 32'h00006655);
        run(43);
        b = rx_q.size();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cp", can_push, 4);
        run(250);
        chk("rst_frames", rx_q.size() - b, 0);

        // Steady single-byte pushes that back up and wrap the FIFO.
        b = rx_q.size();
        for (int i = 0; i < 12; i++) begin
            w = 0;
            while (can_push == 0 && w < 200) begin
                cycle();
                w++;
            end
            chk("wrap_wait", (w < 200) ? 1 : 0, 1);
            put(1, i);
            run(59);
        end
        run(700);
        chk("wrap_frames", rx_q.size() - b, 12);

        // Random bursts, including oversized requests.
        repeat (300) begin
            data = {$urandom, $urandom} >> ($urandom_range(0, 1) * 8);
            data = $urandom;
            push = 3'($urandom_range(0, 4));
            cycle();
            push = '0;
            if ($urandom_range(0, 3) == 0) run($urandom_range(1, 40));
        end
        run(600);

        chk("rx_count", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk("rx_byte", rx_q[i], sent_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
